// File: rtl/lunc_mc.sv
// lunc_mc: multi-channel escape-driven case transformer with one-cycle registered output.
module lunc_mc #(
  parameter int          CHAN_W   = 2,
  parameter logic [7:0]  ESC_CHAR = 8'h1b,
  localparam int         CHANNELS = 2**CHAN_W
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [CHAN_W-1:0]   in_chan_i,
  input  logic [7:0]          in_data_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [CHAN_W-1:0]   out_chan_o,
  output logic [7:0]          out_data_o,
  input  logic                err_clr_i,
  output logic [CHANNELS-1:0] cmd_err_o,
  output logic [CHANNELS-1:0] esc_pend_o
);
  typedef enum logic [1:0] {M_N, M_L, M_U, M_C} mode_e;
  mode_e               mode_q [CHANNELS];
  mode_e               mode_d [CHANNELS];
  logic [CHANNELS-1:0] esc_q, esc_d, err_q, err_d;
  logic                ov_q, ov_d;
  logic [7:0]          od_q, od_d;
  logic [CHAN_W-1:0]   oc_q, oc_d;
  logic                acc, cur_esc, is_up, is_lo, is_cmd, emit, bad;
  mode_e               cur_mode, cmd_mode;
  logic [7:0]          xf;
  assign in_ready_o  = !ov_q || out_ready_i;
  assign acc         = in_valid_i && in_ready_o;
  assign cur_mode    = mode_q[in_chan_i];
  assign cur_esc     = esc_q[in_chan_i];
  assign is_up       = in_data_i >= 8'h41 && in_data_i <= 8'h5a;
  assign is_lo       = in_data_i >= 8'h61 && in_data_i <= 8'h7a;
  assign xf          = (cur_mode == M_L || cur_mode == M_C) && is_up ? in_data_i + 8'h20 :
                       (cur_mode == M_U || cur_mode == M_C) && is_lo ? in_data_i - 8'h20 : in_data_i;
  assign cmd_mode    = in_data_i == 8'h4c ? M_L : in_data_i == 8'h55 ? M_U :
                       in_data_i == 8'h43 ? M_C : M_N;
  assign is_cmd      = in_data_i == 8'h4e || in_data_i == 8'h4c || in_data_i == 8'h55 || in_data_i == 8'h43;
  // An escaped ESC is the only escaped byte that produces output.
  assign emit        = acc && (cur_esc ? in_data_i == ESC_CHAR : in_data_i != ESC_CHAR);
  assign bad         = acc && cur_esc && !is_cmd && in_data_i != ESC_CHAR;
  assign out_valid_o = ov_q;
  assign out_data_o  = od_q;
  assign out_chan_o  = oc_q;
  assign cmd_err_o   = err_q;
  assign esc_pend_o  = esc_q;
  always_comb begin
    mode_d = mode_q;
    esc_d  = esc_q;
    err_d  = err_clr_i ? '0 : err_q;
    ov_d   = emit ? 1'b1 : out_ready_i ? 1'b0 : ov_q;
    od_d   = emit ? (cur_esc ? ESC_CHAR : xf) : od_q;
    oc_d   = emit ? in_chan_i : oc_q;
    if (acc) begin
      esc_d[in_chan_i] = !cur_esc && in_data_i == ESC_CHAR;
      if (cur_esc && is_cmd) mode_d[in_chan_i] = cmd_mode;
      if (bad) err_d[in_chan_i] = 1'b1;
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < CHANNELS; i++) mode_q[i] <= M_N;
      esc_q <= '0;
      err_q <= '0;
      ov_q  <= 1'b0;
      od_q  <= 8'h00;
      oc_q  <= '0;
    end else begin
      mode_q <= mode_d;
      esc_q  <= esc_d;
      err_q  <= err_d;
      ov_q   <= ov_d;
      od_q   <= od_d;
      oc_q   <= oc_d;
    end
  end
endmodule

// File: tb/tb_lunc_mc.sv
// tb_lunc_mc: randomized and directed checks of lunc_mc against a character-level reference model.
module tb_lunc_mc;
  localparam logic [7:0] ESC = 8'h1b;
  logic       clk = 0;
  logic       rst, in_valid, in_ready, out_valid, out_ready, err_clr;
  logic [1:0] in_chan, out_chan;
  logic [7:0] in_data, out_data;
  logic [3:0] cmd_err, esc_pend;
  int checks = 0, failures = 0;
  logic [7:0] m_mode [4];
  logic [3:0] m_esc, m_err;
  logic       m_ov;
  logic [7:0] m_od;
  logic [1:0] m_oc;
  always #5 clk = ~clk;
  lunc_mc dut (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_chan_i(in_chan), .in_data_i(in_data), .out_valid_o(out_valid),
    .out_ready_i(out_ready), .out_chan_o(out_chan), .out_data_o(out_data),
    .err_clr_i(err_clr), .cmd_err_o(cmd_err), .esc_pend_o(esc_pend)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [7:0] xform(input logic [7:0] m, input logic [7:0] d);
    if ((m == "L" || m == "C") && d >= "A" && d <= "Z") return d + 8'd32;
    if ((m == "U" || m == "C") && d >= "a" && d <= "z") return d - 8'd32;
    return d;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < 4; i++) m_mode[i] = "N";
    m_esc = 0; m_err = 0; m_ov = 0; m_od = 0; m_oc = 0;
  endtask
  task automatic step(input logic v, input logic [1:0] c, input logic [7:0] d,
                      input logic ordy, input logic clr = 0, input logic r = 0);
    logic acc, emit;
    logic [7:0] val;
    @(negedge clk);
    in_valid = v; in_chan = c; in_data = d; out_ready = ordy; err_clr = clr; rst = r;
    #1;
    check("in_ready", in_ready, !m_ov || ordy);
    if (r) m_reset();
    else begin
      acc = v && (!m_ov || ordy);
      emit = 0;
      val = 0;
      if (clr) m_err = 0;
      if (acc) begin
        if (!m_esc[c]) begin
          if (d == ESC) m_esc[c] = 1;
          else begin emit = 1; val = xform(m_mode[c], d); end
        end else begin
          m_esc[c] = 0;
          if (d == "N" || d == "L" || d == "U" || d == "C") m_mode[c] = d;
          else if (d == ESC) begin emit = 1; val = ESC; end
          else m_err[c] = 1;
        end
      end
      if (emit) begin m_ov = 1; m_od = val; m_oc = c; end
      else if (ordy) m_ov = 0;
    end
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_ov);
    if (m_ov || r) begin
      check("out_data", out_data, m_od);
      check("out_chan", out_chan, m_oc);
    end
    check("esc_pend", esc_pend, m_esc);
    check("cmd_err", cmd_err, m_err);
  endtask
  function automatic logic [7:0] pick();
    logic [7:0] t [10];
    t = '{ESC, "N", "L", "U", "C", "Z", "a", "B", "{", 8'h00};
    case ($urandom_range(0, 2))
      0: return 8'($urandom);
      default: return t[$urandom_range(0, 8)];
    endcase
  endfunction
  initial begin
    rst = 1; in_valid = 0; in_chan = 0; in_data = 0; out_ready = 1; err_clr = 0;
    m_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 0;
    #1;
    check("rst_ov", out_valid, 0);
    check("rst_od", out_data, 8'h00);
    check("rst_rdy", in_ready, 1);
    step(1, 0, "a", 1); check("tp1_a", out_data, 8'h61);
    step(1, 0, "B", 1); check("tp1_B", out_data, 8'h42);
    step(1, 0, "1", 1); check("tp1_1", out_data, 8'h31);
    step(1, 1, ESC, 1); step(1, 1, "U", 1);
    step(1, 1, "a", 1); check("tp2_a", out_data, 8'h41);
    step(1, 1, "b", 1); check("tp2_b", out_data, 8'h42);
    step(1, 1, "{", 1); check("tp2_br", out_data, 8'h7b);
    step(1, 0, ESC, 1); step(1, 2, ESC, 1); step(1, 0, "L", 1); step(1, 2, "C", 1);
    step(1, 0, "Q", 1); check("tp3_q0", out_data, 8'h71);
    step(1, 2, "q", 1); check("tp3_q2", out_data, 8'h51);
    step(1, 3, ESC, 1); step(1, 3, "Z", 1); check("tp4_err", cmd_err[3], 1);
    step(1, 3, ESC, 1); step(1, 3, ESC, 1); check("tp4_esc", out_data, ESC);
    step(1, 3, "x", 1); check("tp4_x", out_data, 8'h78);
    step(0, 0, 0, 1, 1); check("tp4_clr", cmd_err[3], 0);
    step(1, 0, "m", 1);
    step(1, 1, "n", 0); step(1, 2, "o", 0); step(1, 3, "p", 0);
    check("bp_rdy", in_ready, 0);
    step(1, 1, "n", 1); step(1, 2, "o", 1); step(1, 3, "p", 1);
    step(1, 0, ESC, 1); step(1, 0, "L", 1); step(1, 1, ESC, 1);
    step(1, 0, "a", 0);
    step(1, 0, "Z", 0, 0, 1);
    check("rr_ov", out_valid, 0);
    check("rr_esc", esc_pend, 0);
    step(1, 0, "A", 1); check("rr_A", out_data, 8'h41);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, 2'($urandom), pick(), $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0, $urandom_range(0, 199) == 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
